// File: rtl/data_checker_pkg.sv
// Shared definitions for the pattern generator / checker pair: pattern codes,
// first-word seeds, counter widths and the checker FSM state encoding.
package data_checker_pkg;

  // Word width is tied to eight byte lanes; the byte-lane pattern relies on it
  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;

  // Pattern select codes as seen on the 32-bit pattern port
  localparam logic [1:0]  PAT_BYTECNT = 2'd0;
  localparam logic [1:0]  PAT_CNT64   = 2'd1;
  localparam logic [1:0]  PAT_WALK1   = 2'd2;
  localparam logic [31:0] PAT_LAST    = 32'd2;

  // First word each pattern produces after enable
  localparam logic [DATA_W-1:0] SEED_BYTECNT = 64'h0706_0504_0302_0100;
  localparam logic [DATA_W-1:0] SEED_CNT64   = 64'h0000_0000_0000_0000;
  localparam logic [DATA_W-1:0] SEED_WALK1   = 64'h0000_0000_0000_0001;

  localparam logic [CNT_W-1:0]  CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Seed lookup; unsupported codes yield zero so nothing meaningful is seeded
  function automatic logic [DATA_W-1:0] patternSeed(input logic [1:0] pat);
    logic [DATA_W-1:0] seed;
    case (pat)
      PAT_BYTECNT: seed = SEED_BYTECNT;
      PAT_CNT64:   seed = SEED_CNT64;
      PAT_WALK1:   seed = SEED_WALK1;
      default:     seed = '0;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/data_checker_if.sv
// Host-side bus of the data checker: run control, the received-word
// handshake and the status readout, bundled so the top keeps a short port list.
interface data_checker_if;
  import data_checker_pkg::*;

  logic [31:0]       pattern;
  logic              start;
  logic [CNT_W-1:0]  expected_count;
  logic [DATA_W-1:0] datain;
  logic              datain_valid;
  logic              datain_ready;
  logic              busy;
  logic              done;
  logic              pass;
  logic              pattern_err;
  logic [CNT_W-1:0]  word_count;
  logic [CNT_W-1:0]  error_count;
  logic [CNT_W-1:0]  first_err_index;
  logic [DATA_W-1:0] first_err_data;
  logic [DATA_W-1:0] first_err_expected;

  // Driver side: the pipe/FIFO output plus the register readout
  modport master (
    output pattern, start, expected_count, datain, datain_valid,
    input  datain_ready, busy, done, pass, pattern_err, word_count,
           error_count, first_err_index, first_err_data, first_err_expected
  );

  // Checker side
  modport slave (
    input  pattern, start, expected_count, datain, datain_valid,
    output datain_ready, busy, done, pass, pattern_err, word_count,
           error_count, first_err_index, first_err_data, first_err_expected
  );

endinterface

// File: rtl/data_checker_pattern_step.sv
// One step of every supported test pattern. Purely combinational and shared
// with the generator so both ends of the link advance identically.
module pattern_step
  import data_checker_pkg::*;
(
  input  logic [1:0]        i_pattern,
  input  logic [DATA_W-1:0] i_cur,
  output logic [DATA_W-1:0] o_next
);

  // Next word: per-lane +8, 64-bit increment, or rotate-left walking one
  always_comb begin
    o_next = i_cur;
    case (i_pattern)
      PAT_BYTECNT: begin
        for (int i = 0; i < DATA_W / 8; i++) begin
          o_next[i*8 +: 8] = i_cur[i*8 +: 8] + 8'd8;
        end
      end
      PAT_CNT64: o_next = i_cur + 64'd1;
      PAT_WALK1: o_next = {i_cur[DATA_W-2:0], i_cur[DATA_W-1]};
      default:   o_next = i_cur;
    endcase
  end

endmodule

// File: rtl/data_checker.sv
// Receive-side pattern checker. Regenerates the expected pattern locally,
// compares every accepted word and keeps run statistics for the readout.
module data_checker
  import data_checker_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  data_checker_if.slave bus
);

  state_e            r_state;
  state_e            w_stateNext;
  logic [1:0]        r_pattern;
  logic [CNT_W-1:0]  r_expectedCount;
  logic [DATA_W-1:0] r_expected;
  logic [DATA_W-1:0] w_expectedNext;
  logic              r_patternErr;
  logic [CNT_W-1:0]  r_wordCount;
  logic [CNT_W-1:0]  r_errorCount;
  logic [CNT_W-1:0]  r_firstErrIndex;
  logic [DATA_W-1:0] r_firstErrData;
  logic [DATA_W-1:0] r_firstErrExpected;
  logic              w_patternOk;
  logic              w_runEmpty;
  logic              w_accept;
  logic              w_mismatch;
  logic              w_lastWord;
  logic              w_ready;
  logic              w_busy;
  logic              w_done;

  assign w_patternOk = (bus.pattern <= PAT_LAST);
  assign w_runEmpty  = (bus.expected_count == '0);
  // A start in the same cycle drops the word, so it never counts as accepted
  assign w_accept    = w_ready && bus.datain_valid && !bus.start;
  assign w_mismatch  = (bus.datain != r_expected);
  assign w_lastWord  = ((r_wordCount + CNT_ONE) == r_expectedCount);

  pattern_step u_patternStep (
    .i_pattern (r_pattern),
    .i_cur     (r_expected),
    .o_next    (w_expectedNext)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and state-decoded outputs; start restarts from any state
  always_comb begin
    w_stateNext = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_CHECK: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
    if (bus.start) begin
      if (!w_patternOk || w_runEmpty) begin
        w_stateNext = ST_DONE;
      end else begin
        w_stateNext = ST_CHECK;
      end
    end else if (w_accept && w_lastWord) begin
      w_stateNext = ST_DONE;
    end
  end

  // Run configuration latched at start, expected word advanced on each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern       <= '0;
      r_expectedCount <= '0;
      r_expected      <= '0;
      r_patternErr    <= 1'b0;
    end else if (bus.start) begin
      r_pattern       <= w_patternOk ? bus.pattern[1:0] : PAT_BYTECNT;
      r_expectedCount <= bus.expected_count;
      r_expected      <= w_patternOk ? patternSeed(bus.pattern[1:0]) : '0;
      r_patternErr    <= !w_patternOk;
    end else if (w_accept) begin
      r_expected      <= w_expectedNext;
    end
  end

  // Word/error counters and first-failure capture, cleared on every start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wordCount        <= '0;
      r_errorCount       <= '0;
      r_firstErrIndex    <= '0;
      r_firstErrData     <= '0;
      r_firstErrExpected <= '0;
    end else if (bus.start) begin
      r_wordCount        <= '0;
      r_errorCount       <= '0;
      r_firstErrIndex    <= '0;
      r_firstErrData     <= '0;
      r_firstErrExpected <= '0;
    end else if (w_accept) begin
      r_wordCount <= r_wordCount + CNT_ONE;
      if (w_mismatch) begin
        if (r_errorCount != '1) begin
          r_errorCount <= r_errorCount + CNT_ONE;
        end
        // A saturating count never returns to zero, so zero marks the first failure
        if (r_errorCount == '0) begin
          r_firstErrIndex    <= r_wordCount;
          r_firstErrData     <= bus.datain;
          r_firstErrExpected <= r_expected;
        end
      end
    end
  end

  assign bus.datain_ready       = w_ready;
  assign bus.busy               = w_busy;
  assign bus.done               = w_done;
  assign bus.pass               = w_done && (r_errorCount == '0) && !r_patternErr;
  assign bus.pattern_err        = r_patternErr;
  assign bus.word_count         = r_wordCount;
  assign bus.error_count        = r_errorCount;
  assign bus.first_err_index    = r_firstErrIndex;
  assign bus.first_err_data     = r_firstErrData;
  assign bus.first_err_expected = r_firstErrExpected;

endmodule
